io_irq_ctrl: RTL and testbench

//  Input-side peripheral for the cpu core: owns the i1..i4 data inputs and the ie1..ie4 interrupt lines.
//  - Synchronises NCH asynchronous external WIDTH-bit ports and detects value changes.
//  - Captures changed values into CPU-visible registers.
//  - Raises a prioritised, one-hot interrupt request that the CPU clears with an explicit acknowledge.

---
 rtl/cpu_io_pkg.sv | 14 +
 rtl/io_sync_edge.sv | 35 +++
 rtl/io_irq_ctrl.sv | 98 +++++++++
 tb/tb_io_irq_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
// Shared sizing for the CPU input-port / interrupt peripheral, plus a channel-slice helper.
package cpu_io_pkg;

   localparam int IO_WIDTH = 8;
   localparam int IO_NCH   = 4;
   localparam int IO_IDW   = $clog2(IO_NCH);

   // Extract channel n from a packed bus of IO_NCH channels of IO_WIDTH bits
   function automatic logic [IO_WIDTH-1:0] io_chan(input logic [IO_NCH*IO_WIDTH-1:0] bus,
                                                   input int n);
      return bus[n*IO_WIDTH +: IO_WIDTH];
   endfunction

endpackage

// File: rtl/io_sync_edge.sv
// One channel of input synchronisation: a SYNC_STAGES-deep flop chain followed by a
// prev register, flagging any difference between the synced value and the previous one.
module io_sync_edge
   import cpu_io_pkg::*;
#(
   parameter int WIDTH       = IO_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             change
);

   logic [WIDTH-1:0] sync_p [SYNC_STAGES];
   logic [WIDTH-1:0] prev_p;

   // Synchroniser chain and previous-value register, both cleared asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
         prev_p <= '0;
      end else begin
         sync_p[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
         // prev tracks unconditionally so a re-enabled channel never fires on stale data
         prev_p <= sync_p[SYNC_STAGES-1];
      end
   end

   assign q      = sync_p[SYNC_STAGES-1];
   assign change = (sync_p[SYNC_STAGES-1] != prev_p);

endmodule

// File: rtl/io_irq_ctrl.sv
// Input-side peripheral: synchronises NCH external ports, captures changed values for the
// CPU and raises a fixed-priority one-hot interrupt, cleared by an explicit acknowledge.
module io_irq_ctrl
   import cpu_io_pkg::*;
#(
   parameter  int WIDTH       = IO_WIDTH,
   parameter  int NCH         = IO_NCH,
   parameter  int SYNC_STAGES = 2,
   localparam int IDW         = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH*WIDTH-1:0] ext_in,
   input  logic [NCH-1:0]       en,
   input  logic                 ack,
   input  logic [IDW-1:0]       ack_id,
   output logic [NCH*WIDTH-1:0] cpu_in,
   output logic [NCH-1:0]       ie,
   output logic                 irq_any,
   output logic [IDW-1:0]       irq_id,
   output logic [NCH-1:0]       overrun
);

   logic [WIDTH-1:0] sync_val [NCH];
   logic [NCH-1:0]   raw_chg;
   logic [NCH-1:0]   chg;
   logic [NCH-1:0]   ack_hit;
   logic [NCH-1:0]   pending;
   logic [NCH-1:0]   req;
   logic [NCH-1:0]   ie_nxt;
   logic [IDW-1:0]   id_nxt;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      io_sync_edge #(
         .WIDTH       (WIDTH),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk    (clk),
         .reset  (reset),
         .d      (ext_in[g*WIDTH +: WIDTH]),
         .q      (sync_val[g]),
         .change (raw_chg[g])
      );

      assign chg[g] = raw_chg[g] & en[g];
      // Only an ack naming a pending channel does anything; out-of-range ids match nothing
      assign ack_hit[g] = ack && (ack_id == IDW'(g)) && pending[g];
   end

   // Capture changed values and maintain pending/overrun flags; a change beats a same-edge ack
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_in  <= '0;
         pending <= '0;
         overrun <= '0;
      end else begin
         for (int n = 0; n < NCH; n++) begin
            if (chg[n]) begin
               cpu_in[n*WIDTH +: WIDTH] <= sync_val[n];
               pending[n]               <= 1'b1;
               overrun[n]               <= ack_hit[n] ? 1'b0 : (overrun[n] | pending[n]);
            end else if (ack_hit[n]) begin
               pending[n] <= 1'b0;
               overrun[n] <= 1'b0;
            end
         end
      end
   end

   assign req = pending & en;

   // Fixed-priority encoder: lowest-index enabled pending channel wins
   always_comb begin
      ie_nxt = '0;
      id_nxt = '0;
      for (int n = NCH - 1; n >= 0; n--) begin
         if (req[n]) begin
            ie_nxt    = '0;
            ie_nxt[n] = 1'b1;
            id_nxt    = IDW'(n);
         end
      end
   end

   // Register the request together with its summary bits so they always agree
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ie      <= '0;
         irq_any <= 1'b0;
         irq_id  <= '0;
      end else begin
         ie      <= ie_nxt;
         irq_any <= |ie_nxt;
         irq_id  <= id_nxt;
      end
   end

endmodule

// File: tb/tb_io_irq_ctrl.sv
// Scoreboard bench for io_irq_ctrl: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_io_irq_ctrl;
   import cpu_io_pkg::*;

   localparam int K_CPU = 0;
   localparam int K_IE  = 1;
   localparam int K_ID  = 2;
   localparam int K_ANY = 3;
   localparam int K_OVR = 4;

   logic                       clk = 1'b0;
   logic                       reset;
   logic [IO_NCH*IO_WIDTH-1:0] ext_in;
   logic [IO_NCH-1:0]          en;
   logic                       ack;
   logic [IO_IDW-1:0]          ack_id;
   logic [IO_NCH*IO_WIDTH-1:0] cpu_in;
   logic [IO_NCH-1:0]          ie;
   logic                       irq_any;
   logic [IO_IDW-1:0]          irq_id;
   logic [IO_NCH-1:0]          overrun;

   io_irq_ctrl dut (
      .clk     (clk),
      .reset   (reset),
      .ext_in  (ext_in),
      .en      (en),
      .ack     (ack),
      .ack_id  (ack_id),
      .cpu_in  (cpu_in),
      .ie      (ie),
      .irq_any (irq_any),
      .irq_id  (irq_id),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          at;
      int          kind;
      int          ch;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] act_of(input int kind, input int ch);
      case (kind)
         K_CPU:   return 32'(io_chan(cpu_in, ch));
         K_IE:    return 32'(ie);
         K_ID:    return 32'(irq_id);
         K_ANY:   return 32'(irq_any);
         default: return 32'(overrun[ch]);
      endcase
   endfunction

   // Monitor: compare every expectation due on this cycle
   initial forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at <= cyc) begin
            chk(sb[i].name, act_of(sb[i].kind, sb[i].ch), sb[i].val);
            sb.delete(i);
         end
      end
   end

   task automatic e(input int dly, input int kind, input int ch, input logic [31:0] v,
                    input string name);
      exp_t x;
      x.at   = cyc + dly;
      x.kind = kind;
      x.ch   = ch;
      x.val  = v;
      x.name = name;
      sb.push_back(x);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic [7:0] v);
      ext_in[ch*IO_WIDTH +: IO_WIDTH] = v;
   endtask

   task automatic do_ack(input int id);
      ack    = 1'b1;
      ack_id = IO_IDW'(id);
      tick(1);
      ack    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b0;
      ext_in = '0;
      en     = '0;
      ack    = 1'b0;
      ack_id = '0;
      tick(1);

      // 1. reset held while inputs toggle
      for (int i = 0; i < 4; i++) begin
         ext_in = 32'hA5A5_5A5A ^ (i * 32'h1111_1111);
         en     = 4'hF;
         e(0, K_IE, 0, 0, "t1 ie");
         e(0, K_CPU, i, 0, "t1 cpu_in");
         e(0, K_OVR, i, 0, "t1 overrun");
         tick(1);
      end
      ext_in = '0;
      tick(3);
      reset = 1'b1;
      tick(4);
      e(0, K_IE, 0, 0, "post-reset ie");
      tick(1);

      // 2. single event on ch1
      set_ch(1, 8'h08);
      e(2, K_CPU, 1, 8'h00, "t2 cpu_in early");
      e(3, K_CPU, 1, 8'h08, "t2 cpu_in");
      e(3, K_IE,  0, 4'b0000, "t2 ie early");
      e(4, K_IE,  0, 4'b0010, "t2 ie");
      e(4, K_ID,  0, 1, "t2 irq_id");
      e(4, K_ANY, 0, 1, "t2 irq_any");
      tick(6);
      e(1, K_IE,  0, 4'b0010, "t2 ie held");
      e(2, K_IE,  0, 4'b0000, "t2 ie cleared");
      e(2, K_ANY, 0, 0, "t2 irq_any cleared");
      do_ack(1);
      tick(3);

      // 3. priority between ch0 and ch2
      set_ch(0, 8'h11);
      set_ch(2, 8'h22);
      e(4, K_IE, 0, 4'b0001, "t3 ie ch0");
      e(4, K_ID, 0, 0, "t3 irq_id 0");
      tick(6);
      e(1, K_IE, 0, 4'b0001, "t3 ie ch0 held");
      e(2, K_IE, 0, 4'b0100, "t3 ie ch2");
      e(2, K_ID, 0, 2, "t3 irq_id 2");
      do_ack(0);
      tick(3);
      e(2, K_IE,  0, 4'b0000, "t3 ie cleared");
      e(2, K_ANY, 0, 0, "t3 irq_any cleared");
      do_ack(2);
      tick(3);

      // 4. overrun on ch3
      set_ch(3, 8'h04);
      tick(6);
      do_ack(3);
      tick(3);
      set_ch(3, 8'h10);
      e(3, K_OVR, 3, 0, "t4 overrun first");
      tick(5);
      set_ch(3, 8'h20);
      e(2, K_OVR, 3, 0, "t4 overrun early");
      e(3, K_OVR, 3, 1, "t4 overrun");
      e(3, K_CPU, 3, 8'h20, "t4 cpu_in latest");
      tick(5);
      e(0, K_IE,  0, 4'b1000, "t4 ie");
      e(1, K_OVR, 3, 0, "t4 overrun cleared");
      e(2, K_IE,  0, 4'b0000, "t4 ie cleared");
      do_ack(3);
      tick(3);

      // 5. masking and re-enable
      en = 4'b1101;
      set_ch(1, 8'h55);
      for (int d = 3; d <= 6; d++) e(d, K_IE, 0, 4'b0000, "t5 ie masked");
      e(4, K_CPU, 1, 8'h08, "t5 cpu_in masked");
      tick(6);
      en = 4'hF;
      e(2, K_IE, 0, 4'b0000, "t5 ie reenable");
      e(4, K_IE, 0, 4'b0000, "t5 ie reenable late");
      tick(5);
      set_ch(1, 8'hAA);
      e(3, K_CPU, 1, 8'hAA, "t5 cpu_in new");
      e(4, K_IE,  0, 4'b0010, "t5 ie new");
      tick(6);
      do_ack(1);
      tick(3);

      // 6. change and ack collide on ch0 while overrun is set
      set_ch(0, 8'h33);
      tick(5);
      set_ch(0, 8'h3C);
      tick(5);
      e(0, K_OVR, 0, 1, "t6 overrun before");
      e(0, K_IE,  0, 4'b0001, "t6 ie before");
      set_ch(0, 8'h44);
      tick(2);
      ack    = 1'b1;
      ack_id = '0;
      e(1, K_CPU, 0, 8'h44, "t6 cpu_in collision");
      e(1, K_OVR, 0, 0, "t6 overrun collision");
      e(1, K_IE,  0, 4'b0001, "t6 ie at collision");
      e(2, K_IE,  0, 4'b0001, "t6 ie held");
      e(3, K_IE,  0, 4'b0001, "t6 ie held late");
      tick(1);
      ack = 1'b0;
      tick(4);
      e(2, K_IE, 0, 4'b0000, "t6 ie cleared");
      do_ack(0);
      tick(3);

      // asynchronous reset mid-run
      set_ch(2, 8'h99);
      e(3, K_CPU, 2, 8'h99, "rst cpu_in before");
      e(4, K_IE,  0, 4'b0100, "rst ie before");
      tick(5);
      #2 reset = 1'b0;
      #1;
      chk("async cpu_in", 32'(cpu_in), 32'h0);
      chk("async ie", 32'(ie), 32'h0);
      chk("async irq_any", 32'(irq_any), 32'h0);
      chk("async irq_id", 32'(irq_id), 32'h0);
      chk("async overrun", 32'(overrun), 32'h0);
      tick(2);
      reset = 1'b1;
      tick(2);

      for (int i = 0; i < sb.size(); i++) begin
         checks++;
         errors++;
         $display("FAIL %s: got unchecked expected check at cycle %0d", sb[i].name, sb[i].at);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
